// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and
// hands each fetched word to decode over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pcp4
);

    localparam logic [XLEN-1:0] ALIGN_MASK = 'h3;
    localparam logic [XLEN-1:0] PC_STEP    = 'h4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pcp4_q, if_pcp4_d;
    logic [XLEN-1:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & ~ALIGN_MASK;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        kill_d         = kill_q;
        if_pc_d        = if_pc_q;
        if_instr_d     = if_instr_q;
        if_pcp4_d      = if_pcp4_q;
        imem_req_valid = 1'b0;
        if_valid       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) pc_d = redirect_aligned;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                imem_req_valid = !redirect_valid;
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                end else if (imem_req_ready) begin
                    req_pc_d = pc_q;
                    kill_d   = 1'b0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) pc_d = redirect_aligned;
                // A response to a request made before a redirect is wrong-path.
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        if_instr_d = imem_rsp_data;
                        if_pc_d    = req_pc_q;
                        if_pcp4_d  = req_pc_q + PC_STEP;
                        pc_d       = req_pc_q + PC_STEP;
                        state_d    = ST_OUT;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            ST_OUT: begin
                if_valid = 1'b1;
                if (redirect_valid) begin
                    pc_d    = redirect_aligned;
                    state_d = ST_REQ;
                end else if (if_ready) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            kill_q     <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_pcp4_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_pcp4_q  <= if_pcp4_d;
        end
    end

    assign imem_req_addr = pc_q & ~ALIGN_MASK;
    assign if_pc         = if_pc_q;
    assign if_instr      = if_instr_q;
    assign if_pcp4       = if_pcp4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed table, hand-written corner sequences,
// then random traffic against a transaction-level model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pcp4;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pcp4        (if_pcp4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: what the fetch unit is currently doing.
    bit          m_known = 1'b0;
    bit          m_fresh;      // first cycle after reset, nothing issued yet
    bit          m_busy;       // a request was accepted, response not yet seen
    bit          m_poison;     // that response belongs to a squashed path
    bit          m_show;       // an instruction is being offered to decode
    logic [31:0] m_pc, m_req_pc, m_if_pc, m_if_instr, m_if_pcp4;
    bit          m_accepted;
    logic [31:0] m_acc_addr;

    function automatic bit m_requesting();
        return !(m_fresh || m_busy || m_show);
    endfunction

    task automatic model_update();
        logic [31:0] tgt;
        tgt = {redirect_pc[31:2], 2'b00};
        m_accepted = 1'b0;
        if (rst) begin
            m_known = 1'b1; m_fresh = 1'b1; m_busy = 1'b0; m_poison = 1'b0; m_show = 1'b0;
            m_pc = RESET_PC; m_req_pc = 0; m_if_pc = 0; m_if_instr = 0; m_if_pcp4 = 0;
        end else if (m_fresh) begin
            m_fresh = 1'b0;
            if (redirect_valid) m_pc = tgt;
        end else if (m_busy) begin
            if (redirect_valid) m_pc = tgt;
            if (imem_rsp_valid) begin
                m_busy = 1'b0;
                if (m_poison || redirect_valid) begin
                    m_poison = 1'b0;
                end else begin
                    m_show     = 1'b1;
                    m_if_pc    = m_req_pc;
                    m_if_instr = imem_rsp_data;
                    m_if_pcp4  = m_req_pc + 32'd4;
                    m_pc       = m_req_pc + 32'd4;
                end
            end else if (redirect_valid) begin
                m_poison = 1'b1;
            end
        end else if (m_show) begin
            if (redirect_valid) begin
                m_pc   = tgt;
                m_show = 1'b0;
            end else if (if_ready) begin
                m_show = 1'b0;
            end
        end else begin
            if (redirect_valid) begin
                m_pc = tgt;
            end else if (imem_req_ready) begin
                m_accepted = 1'b1;
                m_acc_addr = m_pc & ~32'h3;
                m_req_pc   = m_pc;
                m_busy     = 1'b1;
                m_poison   = 1'b0;
            end
        end
    endtask

    task automatic settle();
        #1;
        if (m_known) begin
            check("model_req_valid", imem_req_valid, m_requesting() && !redirect_valid);
            check("model_req_addr", imem_req_addr, m_pc & ~32'h3);
            check("model_if_valid", if_valid, m_show);
            check("model_if_pc", if_pc, m_if_pc);
            check("model_if_instr", if_instr, m_if_instr);
            check("model_if_pcp4", if_pcp4, m_if_pcp4);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic quiet_inputs();
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
    endtask

    // From REQ: issue, wait lat cycles, return data; ends in OUT.
    task automatic run_fetch(input logic [31:0] data, input int lat);
        quiet_inputs();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 1; i < lat; i++) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        quiet_inputs();
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0] ^ 16'h5A5A, addr[31:16] + 16'h0013};
    endfunction

    typedef struct {
        logic        ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        if_rdy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_pcp4;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int          mem_cnt;
        logic [31:0] mem_addr;

        // Zero-wait memory, decode always ready: one instruction every 3 cycles.
        tbl[0] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,        32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,        32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h00000013, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,        32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h4, 1'b1, 32'h0, 32'h00000013, 32'h4};
        tbl[4] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h00000013, 32'h4};
        tbl[5] = '{1'b1, 1'b1, 32'h00100093, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h00000013, 32'h4};
        tbl[6] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8, 1'b1, 32'h4, 32'h00100093, 32'h8};
        tbl[7] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8, 1'b0, 32'h4, 32'h00100093, 32'h8};
        tbl[8] = '{1'b1, 1'b1, 32'h00200113, 1'b1, 1'b0, 32'h8, 1'b0, 32'h4, 32'h00100093, 32'h8};
        tbl[9] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'hC, 1'b1, 32'h8, 32'h00200113, 32'hC};

        quiet_inputs();
        rst = 1'b1;
        advance();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            imem_req_ready = tbl[i].ready;
            imem_rsp_valid = tbl[i].rsp_valid;
            imem_rsp_data  = tbl[i].rsp_data;
            if_ready       = tbl[i].if_rdy;
            settle();
            check("tbl_req_valid", imem_req_valid, tbl[i].exp_rv);
            check("tbl_req_addr", imem_req_addr, tbl[i].exp_addr);
            check("tbl_if_valid", if_valid, tbl[i].exp_iv);
            check("tbl_if_pc", if_pc, tbl[i].exp_pc);
            check("tbl_if_instr", if_instr, tbl[i].exp_instr);
            check("tbl_if_pcp4", if_pcp4, tbl[i].exp_pcp4);
            advance();
        end

        // Stall decode for 5 cycles on the word at 0x10.
        run_fetch(32'h00000033, 1);
        if_ready = 1'b1;
        tick();
        run_fetch(32'h00500093, 1);
        for (int i = 0; i < 5; i++) begin
            settle();
            check("stall_if_valid", if_valid, 1'b1);
            check("stall_if_pc", if_pc, 32'h10);
            check("stall_if_instr", if_instr, 32'h00500093);
            check("stall_no_req", imem_req_valid, 1'b0);
            advance();
        end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        settle();
        check("stall_next_addr", imem_req_addr, 32'h14);
        check("stall_next_req", imem_req_valid, 1'b1);

        // Redirect while waiting on a 3-cycle response.
        imem_req_ready = 1'b1;
        advance();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
        settle();
        check("wait_redir_if_valid", if_valid, 1'b0);
        advance();
        imem_rsp_valid = 1'b0;
        settle();
        check("wait_redir_if_valid2", if_valid, 1'b0);
        check("wait_redir_addr", imem_req_addr, 32'h200);
        check("wait_redir_req", imem_req_valid, 1'b1);

        // Unaligned redirect while requesting with memory ready.
        redirect_valid = 1'b1; redirect_pc = 32'h103; imem_req_ready = 1'b1;
        settle();
        check("req_redir_valid", imem_req_valid, 1'b0);
        advance();
        quiet_inputs();
        settle();
        check("req_redir_addr", imem_req_addr, 32'h100);
        check("req_redir_req", imem_req_valid, 1'b1);

        // Redirect in OUT coincident with decode ready.
        run_fetch(32'h00A00513, 2);
        if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        settle();
        check("out_redir_pre_valid", if_valid, 1'b1);
        advance();
        quiet_inputs();
        settle();
        check("out_redir_if_valid", if_valid, 1'b0);
        check("out_redir_addr", imem_req_addr, 32'h40);

        // PC wraps past the top of memory.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        run_fetch(32'h00000073, 1);
        settle();
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_if_pcp4", if_pcp4, 32'h0);
        check("wrap_pc_addr", imem_req_addr, 32'h0);
        if_ready = 1'b1;
        advance();
        if_ready = 1'b0;
        settle();
        check("wrap_next_req", imem_req_valid, 1'b1);
        check("wrap_next_addr", imem_req_addr, 32'h0);

        // Reset while waiting; the late response must be ignored.
        imem_req_ready = 1'b1;
        advance();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000BAD0;
        settle();
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pcp4", if_pcp4, 32'h0);
        advance();
        imem_rsp_valid = 1'b0;
        settle();
        check("rst_first_req", imem_req_valid, 1'b1);
        check("rst_first_addr", imem_req_addr, RESET_PC);
        check("rst_late_ignored", if_valid, 1'b0);
        advance();

        // Random traffic against the model; memory answers 1..3 cycles after acceptance.
        mem_cnt  = 0;
        mem_addr = '0;
        for (int n = 0; n < 3000; n++) begin
            redirect_valid = ($urandom % 8) == 0;
            redirect_pc    = $urandom;
            imem_req_ready = ($urandom % 4) != 0;
            if_ready       = ($urandom % 3) != 0;
            if (mem_cnt == 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
            end else begin
                imem_rsp_valid = (mem_cnt == 0) && (($urandom % 6) == 0);
                imem_rsp_data  = $urandom;
            end
            tick();
            if (m_accepted) begin
                mem_cnt  = $urandom_range(1, 3);
                mem_addr = m_acc_addr;
            end else if (mem_cnt > 0) begin
                mem_cnt--;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
